// File: rtl/rate_timer_pkg.sv
// Shared clock rate, period constants and width defaults for rate timers.
// Periods are clk cycles at CLK_HZ.
package rate_timer_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int CNT_W_DEFAULT = 26;

  localparam int PERIOD_1HZ   = CLK_HZ / 1;
  localparam int PERIOD_2HZ   = CLK_HZ / 2;
  localparam int PERIOD_5HZ   = CLK_HZ / 5;
  localparam int PERIOD_10HZ  = CLK_HZ / 10;
  localparam int PERIOD_20HZ  = CLK_HZ / 20;
  localparam int PERIOD_50HZ  = CLK_HZ / 50;
  localparam int PERIOD_100HZ = CLK_HZ / 100;
  localparam int PERIOD_1KHZ  = CLK_HZ / 1_000;
  localparam int PERIOD_10KHZ = CLK_HZ / 10_000;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_timer_channel.sv
// One rate channel: period/count registers, tick pulse and level output.
// One-shot mode is built only when RATE_TIMER_ONESHOT_EN is defined.
module rate_timer_channel
  import rate_timer_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int DEFAULT_PERIOD = PERIOD_1HZ
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             wr_oneshot,
  output logic             tick,
  output logic             level,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_COUNT =
    (RST_PERIOD == '0) ? '0 : RST_PERIOD - ONE;

  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             live;
  logic             halted;
  logic             expire;

  assign live  = (period_q != '0);
  assign tick  = en & live & ~halted & (count_q == '0);
  assign level = live & (count_q < (period_q >> 1));
  assign done  = halted;

`ifdef RATE_TIMER_ONESHOT_EN
  logic oneshot_q;
  logic done_q;

  // Mode bit follows writes; done sets on a one-shot tick, clears on re-arm
  always_ff @(posedge clk) begin
    if (!resetn) begin
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (wr) begin
      oneshot_q <= wr_oneshot;
      done_q    <= 1'b0;
    end else if (sync) begin
      done_q <= 1'b0;
    end else if (tick && oneshot_q) begin
      done_q <= 1'b1;
    end
  end

  assign halted = done_q;
  assign expire = oneshot_q;
`else
  logic unused_oneshot;

  assign unused_oneshot = wr_oneshot;
  assign halted = 1'b0;
  assign expire = 1'b0;
`endif

  // Next count: write beats sync beats counting; one-shot holds at 0
  always_comb begin
    count_d = count_q;
    if (wr) begin
      count_d = (wr_period == '0) ? '0 : wr_period - ONE;
    end else if (sync) begin
      count_d = live ? period_q - ONE : '0;
    end else if (en && live && !halted) begin
      if (count_q != '0) begin
        count_d = count_q - ONE;
      end else if (!expire) begin
        count_d = period_q - ONE;
      end
    end
  end

  // Period and count registers with synchronous reset to the default rate
  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_q <= RST_PERIOD;
      count_q  <= RST_COUNT;
    end else begin
      if (wr) begin
        period_q <= wr_period;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rate_timer_bank.sv
// Bank of N_CH programmable rate channels sharing one period write port.
// Optional one-shot mode: define RATE_TIMER_ONESHOT_EN.
module rate_timer_bank
  import rate_timer_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int DEFAULT_PERIOD = PERIOD_1HZ,
  parameter int CH_W           = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_period,
  input  logic             wr_oneshot,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  level,
  output logic [N_CH-1:0]  done
);

  logic            wr_ok;
  logic [N_CH-1:0] wr_sel;

  assign wr_ok = wr_en & (int'(wr_ch) < N_CH);

  // One write strobe per channel; addresses past the last channel hit none
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = wr_ok & (int'(wr_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rate_timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .en         (en[g]),
      .sync       (sync[g]),
      .wr         (wr_sel[g]),
      .wr_period  (wr_period),
      .wr_oneshot (wr_oneshot),
      .tick       (tick[g]),
      .level      (level[g]),
      .done       (done[g])
    );
  end

endmodule

// File: doc/rate_timer_bank.md
# rate_timer_bank

Multi-channel programmable rate generator that produces both a single-cycle `tick` pulse and a ~50% duty `level` square wave per channel. It replaces the family of fixed-divisor game timers (1 Hz … 10 kHz at 50 MHz) with one block. The game FSM, ball/paddle movers and display blinkers can reprogram each channel's period at run time through a write port, and can pause or phase-align any channel.

## Interface
Parameters:
- `N_CH`, 4, number of independent channels
- `CNT_W`, 26, counter/period width in bits
- `DEFAULT_PERIOD`, 50_000_000, period loaded into every channel at reset (1 Hz at 50 MHz)
- `CH_W`, max(1, clog2(N_CH)), channel-select width (derived)

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `en`  in  N_CH  per-channel count enable; low = pause, with state held
- `sync`  in  N_CH  per-channel restart pulse; reloads the count without changing the period
- `wr_en`  in  1  period write strobe
- `wr_ch`  in  CH_W  channel addressed by the write
- `wr_period`  in  CNT_W  new period in clk cycles; 0 = channel stopped
- `wr_oneshot`  in  1  mode bit written with the period (see Configuration)
- `tick`  out  N_CH  one-cycle pulse at end of each period
- `level`  out  N_CH  square wave, high for the last floor(P/2) cycles of each period
- `done`  out  N_CH  one-shot expiry flag

## Operation
- Per-channel state:
  - `period[CNT_W]`
  - `count[CNT_W]`
  - `oneshot`
  - `done`
- Counting: when `en[i]` is high, `period != 0` and `done == 0`:
  - `count == 0` reloads to `period-1`
  - otherwise `count` decrements by 1
  - The counter never underflows or wraps past 0.
- `tick[i] = en[i] & (period != 0) & !done & (count == 0)`. Combinational from registered state.
- `level[i] = (period != 0) & (count < (period >> 1))`. Purely registered-state driven; it holds its value while paused.
- Period P ≥ 2 gives one tick every P enabled cycles. P = 1 gives a tick every enabled cycle with `level` constantly 0. P = 0 gives `tick` 0, `level` 0 and the count held.
- Write: when `wr_en` is high and `wr_ch < N_CH`, on the next edge:
  - `period ← wr_period`
  - `count ← wr_period-1` (0 if `wr_period` = 0)
  - `oneshot ← wr_oneshot`
  - `done ← 0`
  - A write with `wr_ch ≥ N_CH` is ignored.
- Sync: `sync[i]` sets `count ← period-1` and `done ← 0` on the next edge. `period` and `oneshot` are unchanged. Sync applies regardless of `en[i]`.
- Priority, highest first: reset > write > sync > count.
- A `tick` asserted in the same cycle as a write or sync to that channel is still output that cycle; the reload then comes from the write or sync, not from the wrap.

## Timing
- Reset values, for all channels:
  - `period = DEFAULT_PERIOD`
  - `count = DEFAULT_PERIOD-1`
  - `oneshot = 0`, `done = 0`
  - `tick = 0`, `level = 0`
- The first tick after reset release with `en` held high comes DEFAULT_PERIOD cycles after the first enabled edge, i.e. on cycle index DEFAULT_PERIOD-1.
- Write and sync latency: 1 cycle. The first tick after a write of P comes P cycles after the write edge (with `en` high).
- Deasserting `en` mid-period freezes `count`. On re-enable, counting resumes from the frozen value with no tick lost or duplicated.
- Reset asserted mid-period overrides everything on that edge.

## Configuration
- `RATE_TIMER_ONESHOT_EN` defined:
  - A channel with `oneshot = 1` stops after its first tick: `done ← 1` on that edge and `count` holds at 0.
  - While `done` is set, `tick` = 0 and `level` = 1 (count 0 < half, for P ≥ 2).
  - A write or sync re-arms the channel.
- Macro undefined:
  - The `wr_oneshot` port remains but is ignored.
  - The `oneshot` and `done` registers are not built; the `done` output is tied to 0.
  - All channels are periodic.

## Structure
- Shared package `rate_timer_pkg` holds:
  - `CLK_HZ` = 50_000_000
  - named period constants `PERIOD_1HZ`, `PERIOD_2HZ` … `PERIOD_10KHZ`, equal to CLK_HZ/divisor
  - the `CNT_W` default
- Sub-module `rate_timer_channel` (one channel: period/count/oneshot/done registers, tick/level logic) is instantiated N_CH times in a generate loop. The top level does only write-address decode.

## Test plan
- Reset, then `wr_period=4` to ch0 with `en=1`: `tick[0]` high on cycles 4, 8, 12 after the write edge; `level[0]` high for 2 of every 4 cycles, asserted on the cycles at count 1 and 0.
- Write `wr_period=1` to ch1: `tick[1]` high every cycle and `level[1]` constantly 0. Write `wr_period=0`: `tick`/`level` 0 and count frozen.
- Period 8 on ch2 with `en[2]` dropped for 5 cycles at count 3: the next tick arrives exactly 5 cycles later than without the pause; the tick total over 40 cycles is reduced by one period's worth.
- `sync[3]` pulse at count 2 of period 10: the next tick comes 10 cycles after the sync edge. A simultaneous write of 6 to ch3 takes precedence, giving a tick 6 cycles later.
- With `RATE_TIMER_ONESHOT_EN`, write `P=5`, `oneshot=1`: exactly one tick 5 cycles later, `done` rises on the following edge, and there are no further ticks over 50 cycles until a sync re-arms the channel. Without the macro, the same stimulus gives periodic ticks and `done` = 0.
- Write to `wr_ch = N_CH` (out of range, with N_CH=3 and CH_W=2): no channel state changes. `resetn` low mid-count restores DEFAULT_PERIOD and all outputs to 0.
